vga_capture: RTL and testbench
==============================

// Module: vga_capture
// PURPOSE
//  Receive side of the pong VGA output. Watches hsync/vsync/rrggbb and recovers
//  the game state they encode: ball cell, left/right paddle bitmaps, background colour.
//  Sits on the same 31.5 MHz pixel clock as the video generator and feeds
//  self-check logic and loopback benches.
//  Results are double-buffered and published once per frame with a one-cycle strobe.
// PARAMETERS
//  H_TOTAL   832  clk cycles per line (hsync period)
//  H_BP      128  cycles from the hsync trailing edge (x_cnt=0) to active pixel px=0
//  H_ACTIVE  640  active pixels per line
//  V_TOTAL   520  lines per frame (hsync trailing edges between vsync trailing edges)
//  V_BP      28   lines from the vsync trailing edge (y_cnt=0) to active row py=0
//  V_ACTIVE  480  active rows per frame
//  X_OFF     192  px of playfield cell column 0 (must be >0)
//  Y_OFF     112  py of playfield cell row 0
//  SYNC_NEG  1    1: syncs active-low; 0: active-high
// PORTS
//  clk          in   1   pixel clock, 31.5 MHz
//  reset        in   1   asynchronous, active-low (0 = in reset)
//  hsync        in   1   horizontal sync from video source
//  vsync        in   1   vertical sync from video source
//  rrggbb       in   6   pixel colour
//  ball_x       out  5   recovered ball cell column
//  ball_y       out  5   recovered ball cell row
//  ball_found   out  1   1 if a ball cell was seen in the published frame
//  lpaddle      out  32  bit r set = cell (31,r) lit
//  rpaddle      out  32  bit r set = cell (0,r) lit
//  bgcolor      out  6   colour sampled at px=0, py=0
//  frame_valid  out  1   one-cycle strobe: outputs were just updated
//  frame_ok     out  1   published frame had correct line lengths and line count
// BEHAVIOUR
//  - All outputs are 0 while reset is low. Reset mid-frame discards the partial frame.
//  - Inputs are registered once (s1), then once more (s2). All edges are detected as
//    s1 versus s2; the whole block lives in the clk domain.
//  - Counters: x_cnt is cleared on the hsync trailing edge, then +1 per clk.
//    y_cnt is cleared on the vsync trailing edge, then +1 per hsync trailing edge.
//    Both saturate at all-ones.
//  - Active pixel: H_BP <= x_cnt < H_BP+H_ACTIVE and V_BP <= y_cnt < V_BP+V_ACTIVE.
//    px = x_cnt-H_BP, py = y_cnt-V_BP. Pixels outside this window are ignored.
//  - Cell sampling: u = px-X_OFF and v = py-Y_OFF, both 10-bit wrap.
//    Sample only when u[9:8]==0, v[9:8]==0, u[2:0]==4 and v[2:0]==4.
//    Cell coordinates are cx = u[7:3], cy = v[7:3]. Lit means rrggbb == 6'b111111.
//  - cx==31 and lit: set lpaddle_acc[cy]. cx==0 and lit: set rpaddle_acc[cy].
//  - 1<=cx<=30 and lit: the first such cell in raster order is latched into
//    ball_acc and sets found_acc. Later lit cells are ignored.
//    A ball in column 0 or 31 reads as a paddle bit (by design).
//  - bg_acc samples rrggbb at px==0, py==0.
//  - Line check: on each hsync trailing edge, if the previous line had
//    x_cnt+1 != H_TOTAL, set err_acc. Skip this check on the first line after arming.
//  - States:
//    - IDLE (after reset): wait for the vsync trailing edge, then go to ARMED.
//      Clear the accumulators on entry to ARMED.
//    - ARMED: accumulate. On the vsync leading edge:
//      - copy the accumulators to the outputs;
//      - frame_ok = !err_acc && (y_cnt+1 == V_TOTAL);
//      - pulse frame_valid; go to WAIT.
//    - WAIT: on the vsync trailing edge, clear the accumulators and go to ARMED.
//  - Latency: frame_valid rises 2 clk edges after the vsync leading edge is present
//    on the pin. Outputs are stable from that cycle until the next strobe.
//  - Vsync and hsync edges in the same cycle: process the hsync edge first
//    (y_cnt +1), then the vsync edge.
//  - A vsync leading edge in IDLE produces no strobe. The first strobe needs one
//    complete frame after reset.
// TESTING
//  - Nominal frame: ball (5,9), lpaddle=32'h0000_0F00, rpaddle=32'h00F0_0000,
//    bg=6'b000011 -> frame_valid strobe; outputs match; ball_found=1; frame_ok=1.
//  - No ball, paddles 0, bg=6'b110000 -> ball_found=0, lpaddle=rpaddle=0, bgcolor=6'b110000.
//  - Lit cells (3,2) and (7,20) -> ball_x=3, ball_y=2 (first in raster order).
//    Lit cell (31,31) -> lpaddle[31]=1.
//  - One line of 831 clks -> frame_ok=0 for that frame. Next clean frame -> frame_ok=1.
//  - Reset low mid-frame, released mid-frame -> no strobe at the next vsync leading
//    edge; first strobe one full frame later with correct data.
//  - Ball moves (5,9)->(6,9) between frames -> outputs change only at the strobe
//    cycle, exactly 2 clks after the vsync leading edge.

Source files
------------

// File: rtl/vga_capture.sv
// vga_capture: recovers pong game state from a VGA stream on the pixel clock.
//   Watches hsync/vsync/rrggbb, samples the centre of each 8x8 playfield cell,
//   and publishes ball cell, paddle bitmaps, background colour and a frame
//   integrity flag once per frame.
// Ports:
//   clk          pixel clock
//   reset        asynchronous, active-low
//   hsync/vsync  sync inputs (polarity set by SYNC_NEG)
//   rrggbb       pixel colour
//   ball_x/y     published ball cell; ball_found = a ball cell was seen
//   lpaddle      bit r = cell (31,r) lit; rpaddle bit r = cell (0,r) lit
//   bgcolor      colour at px=0, py=0
//   frame_valid  one-cycle strobe when the outputs above were just updated
//   frame_ok     published frame had correct line lengths and line count
module vga_capture #(
  parameter int unsigned H_TOTAL  = 832,
  parameter int unsigned H_BP     = 128,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_TOTAL  = 520,
  parameter int unsigned V_BP     = 28,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned X_OFF    = 192,
  parameter int unsigned Y_OFF    = 112,
  parameter bit          SYNC_NEG = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [5:0]  rrggbb,
  output logic [4:0]  ball_x,
  output logic [4:0]  ball_y,
  output logic        ball_found,
  output logic [31:0] lpaddle,
  output logic [31:0] rpaddle,
  output logic [5:0]  bgcolor,
  output logic        frame_valid,
  output logic        frame_ok
);

  localparam logic [9:0]  XLo  = 10'(H_BP);
  localparam logic [9:0]  XHi  = 10'(H_BP + H_ACTIVE);
  localparam logic [9:0]  YLo  = 10'(V_BP);
  localparam logic [9:0]  YHi  = 10'(V_BP + V_ACTIVE);
  localparam logic [9:0]  UOff = 10'(H_BP + X_OFF);
  localparam logic [9:0]  VOff = 10'(V_BP + Y_OFF);
  localparam logic [10:0] HTot = 11'(H_TOTAL);
  localparam logic [10:0] VTot = 11'(V_TOTAL);

  typedef enum logic [1:0] {StIdle, StArmed, StWait} state_e;

  // Two-stage input registers; s2 colour is aligned with the counters.
  logic       r_hs1, r_hs2, r_vs1, r_vs2;
  logic [5:0] r_rgb1, r_rgb2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Syncs reset to their inactive level so release creates no false edge.
      r_hs1  <= SYNC_NEG;
      r_hs2  <= SYNC_NEG;
      r_vs1  <= SYNC_NEG;
      r_vs2  <= SYNC_NEG;
      r_rgb1 <= '0;
      r_rgb2 <= '0;
    end else begin
      r_hs1  <= hsync;
      r_hs2  <= r_hs1;
      r_vs1  <= vsync;
      r_vs2  <= r_vs1;
      r_rgb1 <= rrggbb;
      r_rgb2 <= r_rgb1;
    end
  end

  logic w_hs_act1, w_hs_act2, w_vs_act1, w_vs_act2;
  logic w_hs_trail, w_vs_lead, w_vs_trail;
  assign w_hs_act1  = r_hs1 ^ SYNC_NEG;
  assign w_hs_act2  = r_hs2 ^ SYNC_NEG;
  assign w_vs_act1  = r_vs1 ^ SYNC_NEG;
  assign w_vs_act2  = r_vs2 ^ SYNC_NEG;
  assign w_hs_trail = ~w_hs_act1 & w_hs_act2;
  assign w_vs_lead  = w_vs_act1 & ~w_vs_act2;
  assign w_vs_trail = ~w_vs_act1 & w_vs_act2;

  // Counters, saturating at all-ones.
  logic [9:0] r_x_cnt, r_y_cnt, w_y_inc;
  assign w_y_inc = (w_hs_trail && r_y_cnt != '1) ? r_y_cnt + 10'd1 : r_y_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_x_cnt <= '0;
      r_y_cnt <= '0;
    end else begin
      if (w_hs_trail)          r_x_cnt <= '0;
      else if (r_x_cnt != '1)  r_x_cnt <= r_x_cnt + 10'd1;
      // hsync edge is applied first, so a coincident vsync trailing edge wins.
      r_y_cnt <= w_vs_trail ? '0 : w_y_inc;
    end
  end

  // Cell sampling at the centre pixel (offset 4,4) of each 8x8 cell.
  logic [9:0] w_u, w_v;
  logic       w_active, w_cell, w_lit, w_bg_pt;
  logic [4:0] w_cx, w_cy;
  assign w_active = (r_x_cnt >= XLo) && (r_x_cnt < XHi) && (r_y_cnt >= YLo) && (r_y_cnt < YHi);
  assign w_u      = r_x_cnt - UOff;
  assign w_v      = r_y_cnt - VOff;
  assign w_cell   = w_active && (w_u[9:8] == 2'b00) && (w_v[9:8] == 2'b00) &&
                    (w_u[2:0] == 3'd4) && (w_v[2:0] == 3'd4);
  assign w_cx     = w_u[7:3];
  assign w_cy     = w_v[7:3];
  assign w_lit    = (r_rgb2 == 6'b111111);
  assign w_bg_pt  = w_active && (r_x_cnt == XLo) && (r_y_cnt == YLo);

  // FSM
  state_e r_state, w_state_next;
  logic   w_arm, w_publish;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_arm        = 1'b0;
    w_publish    = 1'b0;
    unique case (r_state)
      StIdle, StWait: begin
        if (w_vs_trail) begin
          w_arm        = 1'b1;
          w_state_next = StArmed;
        end
      end
      StArmed: begin
        if (w_vs_lead) begin
          w_publish    = 1'b1;
          w_state_next = StWait;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Accumulators and their next values (current cycle folded in).
  logic [31:0] r_lp_acc, r_rp_acc, w_lp_next, w_rp_next;
  logic [4:0]  r_bx_acc, r_by_acc, w_bx_next, w_by_next;
  logic [5:0]  r_bg_acc, w_bg_next;
  logic        r_found_acc, w_found_next, r_err_acc, w_err_next, r_first, w_first_next;
  logic        w_ok;

  always_comb begin
    w_lp_next    = r_lp_acc;
    w_rp_next    = r_rp_acc;
    w_bx_next    = r_bx_acc;
    w_by_next    = r_by_acc;
    w_bg_next    = r_bg_acc;
    w_found_next = r_found_acc;
    w_err_next   = r_err_acc;
    w_first_next = r_first;
    if (w_cell && w_lit) begin
      if (w_cx == 5'd31)      w_lp_next[w_cy] = 1'b1;
      else if (w_cx == 5'd0)  w_rp_next[w_cy] = 1'b1;
      else if (!r_found_acc) begin
        w_bx_next    = w_cx;
        w_by_next    = w_cy;
        w_found_next = 1'b1;
      end
    end
    if (w_bg_pt) w_bg_next = r_rgb2;
    if (w_hs_trail) begin
      // The first line after arming may have started before the arm point.
      w_first_next = 1'b0;
      if (!r_first && ({1'b0, r_x_cnt} + 11'd1 != HTot)) w_err_next = 1'b1;
    end
    w_ok = !w_err_next && ({1'b0, w_y_inc} + 11'd1 == VTot);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lp_acc    <= '0;
      r_rp_acc    <= '0;
      r_bx_acc    <= '0;
      r_by_acc    <= '0;
      r_bg_acc    <= '0;
      r_found_acc <= 1'b0;
      r_err_acc   <= 1'b0;
      r_first     <= 1'b0;
    end else if (w_arm) begin
      r_lp_acc    <= '0;
      r_rp_acc    <= '0;
      r_bx_acc    <= '0;
      r_by_acc    <= '0;
      r_bg_acc    <= '0;
      r_found_acc <= 1'b0;
      r_err_acc   <= 1'b0;
      r_first     <= 1'b1;
    end else if (r_state == StArmed) begin
      r_lp_acc    <= w_lp_next;
      r_rp_acc    <= w_rp_next;
      r_bx_acc    <= w_bx_next;
      r_by_acc    <= w_by_next;
      r_bg_acc    <= w_bg_next;
      r_found_acc <= w_found_next;
      r_err_acc   <= w_err_next;
      r_first     <= w_first_next;
    end
  end

  // Published outputs
  logic [31:0] r_lpaddle, r_rpaddle;
  logic [4:0]  r_ball_x, r_ball_y;
  logic [5:0]  r_bgcolor;
  logic        r_ball_found, r_frame_valid, r_frame_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lpaddle     <= '0;
      r_rpaddle     <= '0;
      r_ball_x      <= '0;
      r_ball_y      <= '0;
      r_bgcolor     <= '0;
      r_ball_found  <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_ok    <= 1'b0;
    end else begin
      r_frame_valid <= w_publish;
      if (w_publish) begin
        r_lpaddle    <= w_lp_next;
        r_rpaddle    <= w_rp_next;
        r_ball_x     <= w_bx_next;
        r_ball_y     <= w_by_next;
        r_bgcolor    <= w_bg_next;
        r_ball_found <= w_found_next;
        r_frame_ok   <= w_ok;
      end
    end
  end

  assign ball_x      = r_ball_x;
  assign ball_y      = r_ball_y;
  assign ball_found  = r_ball_found;
  assign lpaddle     = r_lpaddle;
  assign rpaddle     = r_rpaddle;
  assign bgcolor     = r_bgcolor;
  assign frame_valid = r_frame_valid;
  assign frame_ok    = r_frame_ok;

endmodule

// File: tb/tb_vga_capture.sv
// tb_vga_capture: directed frames through a reduced-timing vga_capture.
//   Geometry: 264 clk/line, 260 lines/frame, active x 4..259, y 2..257,
//   playfield origin at px=1, py=1. Cell (cx,cy) centre: sx=9+8cx, sy=7+8cy.
module tb_vga_capture;

  localparam int HT = 264;
  localparam int VT = 260;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        hsync = 1'b1;
  logic        vsync = 1'b1;
  logic [5:0]  rrggbb = '0;
  logic [4:0]  ball_x, ball_y;
  logic        ball_found, frame_valid, frame_ok;
  logic [31:0] lpaddle, rpaddle;
  logic [5:0]  bgcolor;

  vga_capture #(
    .H_TOTAL (264), .H_BP (4), .H_ACTIVE (256),
    .V_TOTAL (260), .V_BP (2), .V_ACTIVE (256),
    .X_OFF (1), .Y_OFF (1), .SYNC_NEG (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hsync       (hsync),
    .vsync       (vsync),
    .rrggbb      (rrggbb),
    .ball_x      (ball_x),
    .ball_y      (ball_y),
    .ball_found  (ball_found),
    .lpaddle     (lpaddle),
    .rpaddle     (rpaddle),
    .bgcolor     (bgcolor),
    .frame_valid (frame_valid),
    .frame_ok    (frame_ok)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Per-frame stimulus configuration (index 0 = lead-in line only).
  logic [31:0] cfg_lp [0:6];
  logic [31:0] cfg_rp [0:6];
  logic [5:0]  cfg_bg [0:6];
  int          cfg_nb [0:6];
  int          cfg_bx [0:6][0:1];
  int          cfg_by [0:6][0:1];
  int          cfg_short [0:6];
  int          cfg_rst_lo [0:6];
  int          cfg_rst_hi [0:6];
  int          cur_f;

  int          strobe_cnt, strobe_pos, glitch;
  logic [90:0] prev_snap;

  function automatic logic [5:0] pix(input int sx, input int sy);
    int u, v, cx, cy;
    if (sx < 4 || sx > 259 || sy < 2 || sy > 257) return 6'b000000;
    u = sx - 5;
    v = sy - 3;
    if (u >= 0 && v >= 0 && u < 256 && v < 256) begin
      cx = u / 8;
      cy = v / 8;
      if (cx == 31 && cfg_lp[cur_f][cy]) return 6'b111111;
      if (cx == 0 && cfg_rp[cur_f][cy])  return 6'b111111;
      for (int i = 0; i < cfg_nb[cur_f]; i++)
        if (cfg_bx[cur_f][i] == cx && cfg_by[cur_f][i] == cy) return 6'b111111;
    end
    return cfg_bg[cur_f];
  endfunction

  task automatic sample(input int sy, input int sx);
    logic [90:0] snap;
    snap = {ball_x, ball_y, ball_found, lpaddle, rpaddle, bgcolor, frame_ok};
    if (frame_valid) begin
      strobe_cnt++;
      strobe_pos = sy * 1000 + sx;
    end
    if (reset && !frame_valid && snap !== prev_snap) glitch++;
    prev_snap = snap;
  endtask

  task automatic gen_line(input int sy);
    int len;
    len = (sy == cfg_short[cur_f]) ? HT - 1 : HT;
    for (int sx = 0; sx < len; sx++) begin
      @(negedge clk);
      sample(sy, sx);
      if (sx == 0 && sy == cfg_rst_lo[cur_f]) reset = 1'b0;
      if (sx == 0 && sy == cfg_rst_hi[cur_f]) reset = 1'b1;
      if (!reset && sx == 0 && sy == 55) begin
        check("in_reset_found", {31'b0, ball_found}, 32'h0);
        check("in_reset_lpaddle", lpaddle, 32'h0);
      end
      hsync  = !(sx >= 260);
      vsync  = !(sy == VT - 1);
      rrggbb = pix(sx, sy);
    end
  endtask

  task automatic gen_frame(input int f);
    cur_f      = f;
    strobe_cnt = 0;
    strobe_pos = -1;
    glitch     = 0;
    for (int sy = 0; sy < VT; sy++) gen_line(sy);
  endtask

  task automatic set_cfg(input int f, input logic [31:0] lp, input logic [31:0] rp,
                         input logic [5:0] bg, input int nb, input int bx0, input int by0,
                         input int bx1, input int by1, input int short_l);
    cfg_lp[f] = lp;   cfg_rp[f] = rp;   cfg_bg[f] = bg;   cfg_nb[f] = nb;
    cfg_bx[f][0] = bx0; cfg_by[f][0] = by0; cfg_bx[f][1] = bx1; cfg_by[f][1] = by1;
    cfg_short[f] = short_l; cfg_rst_lo[f] = -1; cfg_rst_hi[f] = -1;
  endtask

  task automatic check_frame(input string nm, input int exp_bx, input int exp_by,
                             input logic exp_found, input logic [31:0] exp_lp,
                             input logic [31:0] exp_rp, input logic [5:0] exp_bg,
                             input logic exp_ok);
    check({nm, "_strobes"}, strobe_cnt, 1);
    check({nm, "_strobe_pos"}, strobe_pos, 259002);
    check({nm, "_glitch"}, glitch, 0);
    check({nm, "_found"}, {31'b0, ball_found}, {31'b0, exp_found});
    if (exp_found) begin
      check({nm, "_ball_x"}, {27'b0, ball_x}, exp_bx);
      check({nm, "_ball_y"}, {27'b0, ball_y}, exp_by);
    end
    check({nm, "_lpaddle"}, lpaddle, exp_lp);
    check({nm, "_rpaddle"}, rpaddle, exp_rp);
    check({nm, "_bgcolor"}, {26'b0, bgcolor}, {26'b0, exp_bg});
    check({nm, "_frame_ok"}, {31'b0, frame_ok}, {31'b0, exp_ok});
  endtask

  initial begin
    set_cfg(0, 32'h0, 32'h0, 6'b000000, 0, 0, 0, 0, 0, -1);
    set_cfg(1, 32'h0000_0F00, 32'h00F0_0000, 6'b000011, 1, 5, 9, 0, 0, -1);
    set_cfg(2, 32'h0000_0F00, 32'h00F0_0000, 6'b000011, 1, 6, 9, 0, 0, 100);
    set_cfg(3, 32'h0, 32'h0, 6'b110000, 0, 0, 0, 0, 0, -1);
    set_cfg(4, 32'h8000_0000, 32'h0, 6'b000011, 2, 3, 2, 7, 20, -1);
    set_cfg(5, 32'h0000_0F00, 32'h00F0_0000, 6'b000011, 1, 5, 9, 0, 0, -1);
    cfg_rst_lo[5] = 50;
    cfg_rst_hi[5] = 60;
    set_cfg(6, 32'h0000_0F00, 32'h00F0_0000, 6'b000011, 1, 5, 9, 0, 0, -1);
    cur_f = 0;

    // Pins toggle while in reset; outputs must stay zero.
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      hsync  = i[0];
      vsync  = i[1];
      rrggbb = 6'b111111;
    end
    check("reset_valid", {31'b0, frame_valid}, 32'h0);
    check("reset_found", {31'b0, ball_found}, 32'h0);
    check("reset_lpaddle", lpaddle, 32'h0);
    check("reset_bgcolor", {26'b0, bgcolor}, 32'h0);
    check("reset_frame_ok", {31'b0, frame_ok}, 32'h0);
    @(negedge clk);
    hsync  = 1'b1;
    vsync  = 1'b1;
    rrggbb = '0;
    @(negedge clk);
    reset = 1'b1;
    prev_snap = '0;

    // Lead-in: vsync leading edge seen in IDLE gives no strobe.
    strobe_cnt = 0;
    glitch     = 0;
    gen_line(VT - 1);
    check("idle_lead_strobes", strobe_cnt, 0);

    gen_frame(1);
    check_frame("nominal", 5, 9, 1'b1, 32'h0000_0F00, 32'h00F0_0000, 6'b000011, 1'b1);
    gen_frame(2);
    check_frame("move_short", 6, 9, 1'b1, 32'h0000_0F00, 32'h00F0_0000, 6'b000011, 1'b0);
    gen_frame(3);
    check_frame("no_ball", 0, 0, 1'b0, 32'h0, 32'h0, 6'b110000, 1'b1);
    gen_frame(4);
    check_frame("raster", 3, 2, 1'b1, 32'h8000_0000, 32'h0, 6'b000011, 1'b1);
    gen_frame(5);
    check("rst_frame_strobes", strobe_cnt, 0);
    check("rst_frame_ok", {31'b0, frame_ok}, 32'h0);
    check("rst_frame_rpaddle", rpaddle, 32'h0);
    gen_frame(6);
    check_frame("after_rst", 5, 9, 1'b1, 32'h0000_0F00, 32'h00F0_0000, 6'b000011, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
